// File: rtl/stage_decode.sv
// RV32I decode stage: regfile read, immediate generation, RAW scoreboard, ex pipeline register.
// Latency: 1 cycle fetch->ex. Optional writeback bypass when DECODE_WB_BYPASS_EN is defined.
// Backpressure: de_stall holds fetch on a RAW hazard or when execute stalls with ex occupied.
module stage_decode #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          SB_X0_HARD = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de_valid,
  input  logic [31:0] de_insn,
  input  logic [31:0] de_pc,
  output logic        de_stall,
  input  logic        de_flush,
  input  logic [31:0] flush_keep,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic        ex_illegal
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // One bit per architectural register: set while a write to it is in flight.
  logic [31:0] pend;
  logic [31:0] pend_nxt;

  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        legal;
  logic        use_rs1;
  logic        use_rs2;
  logic        writes_rd;
  logic [31:0] imm;
  logic        byp1;
  logic        byp2;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hazard;
  logic        accept;
  logic        issue;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  assign opcode      = de_insn[6:2];
  assign rd          = de_insn[11:7];
  assign rs1         = de_insn[19:15];
  assign rs2         = de_insn[24:20];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // Classify the opcode: legality, which sources are read, whether rd is written, immediate format.
  always_comb begin
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm       = 32'd0;
    if (de_insn[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
          imm       = {{20{de_insn[31]}}, de_insn[31:20]};
        end
        OPC_MISC: begin
          legal   = 1'b1;
          use_rs1 = 1'b1;
        end
        OPC_AUIPC, OPC_LUI: begin
          legal     = 1'b1;
          writes_rd = 1'b1;
          imm       = {de_insn[31:12], 12'd0};
        end
        OPC_STORE: begin
          legal   = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm     = {{20{de_insn[31]}}, de_insn[31:25], de_insn[11:7]};
        end
        OPC_OP: begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
          writes_rd = 1'b1;
        end
        OPC_BRANCH: begin
          legal   = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm     = {{19{de_insn[31]}}, de_insn[31], de_insn[7], de_insn[30:25], de_insn[11:8], 1'b0};
        end
        OPC_JAL: begin
          legal     = 1'b1;
          writes_rd = 1'b1;
          imm       = {{11{de_insn[31]}}, de_insn[31], de_insn[19:12], de_insn[20], de_insn[30:21], 1'b0};
        end
        default: legal = 1'b0;
      endcase
    end
    // x0 is never a real destination.
    if (rd == 5'd0) writes_rd = 1'b0;
  end

`ifdef DECODE_WB_BYPASS_EN
  // Forward the retiring write straight into the operand and ignore its pending bit.
  always_comb begin
    byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
    byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
    op1  = byp1 ? wb_data : rf_rs1_data;
    op2  = byp2 ? wb_data : rf_rs2_data;
  end
`else
  // Without bypass the consumer waits for the registered pending bit to drop.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
    op1  = rf_rs1_data;
    op2  = rf_rs2_data;
  end
`endif

  // Hazard detection, handshake and scoreboard next-state.
  always_comb begin
    hazard   = (use_rs1 && (rs1 != 5'd0) && pend[rs1] && !byp1) ||
               (use_rs2 && (rs2 != 5'd0) && pend[rs2] && !byp2);
    accept   = !ex_valid || !ex_stall;
    issue    = de_valid && !de_flush && accept && !hazard;
    de_stall = de_valid && !de_flush && (!accept || hazard);
    set_vec  = (issue && writes_rd) ? (32'd1 << rd) : 32'd0;
    clr_vec  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    if (de_flush) pend_nxt = flush_keep & ~clr_vec;
    else          pend_nxt = (pend & ~clr_vec) | set_vec;
    if (de_flush || (SB_X0_HARD != 0)) pend_nxt[0] = 1'b0;
  end

  // Scoreboard and ex pipeline register; fields hold while execute refuses a new insn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= 32'd0;
      ex_valid    <= 1'b0;
      ex_pc       <= RESET_PC;
      ex_opcode   <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_funct7b5 <= 1'b0;
      ex_rd       <= 5'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_illegal  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (de_flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= issue;
        if (issue) begin
          ex_pc       <= de_pc;
          ex_opcode   <= opcode;
          ex_funct3   <= de_insn[14:12];
          ex_funct7b5 <= de_insn[30];
          ex_rd       <= writes_rd ? rd : 5'd0;
          ex_rs1_data <= op1;
          ex_rs2_data <= op2;
          ex_imm      <= imm;
          ex_illegal  <= !legal;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode with a queue of expected ex-register contents.
// Each step advances one clock; outputs are sampled 1-3 time units after the rising edge.
// Execute backpressure is driven explicitly through ex_stall.
module tb_stage_decode;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        reset_n;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;
  logic        de_stall;
  logic        de_flush;
  logic [31:0] flush_keep;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic        ill;
    logic        c1;
    logic        c2;
  } exp_t;

  exp_t exp_q[$];

  stage_decode #(.RESET_PC(RESET_PC), .SB_X0_HARD(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .de_valid(de_valid), .de_insn(de_insn), .de_pc(de_pc), .de_stall(de_stall),
    .de_flush(de_flush), .flush_keep(flush_keep),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_illegal(ex_illegal)
  );

  // Register file model: a fixed, recognisable value per register, x0 reads zero.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'hA500_0000 | (32'h111 * {27'd0, a}));
  endfunction

  assign rf_rs1_data = rf_val(rf_rs1_addr);
  assign rf_rs2_data = rf_val(rf_rs2_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] opc, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd, input logic [31:0] rs1d,
                      input logic [31:0] rs2d, input logic [31:0] imm, input logic ill,
                      input logic c1, input logic c2);
    exp_t e;
    e = '{pc: pc, opc: opc, f3: f3, f7: f7, rd: rd, rs1d: rs1d, rs2d: rs2d,
          imm: imm, ill: ill, c1: c1, c2: c2};
    exp_q.push_back(e);
  endtask

  // Compare the ex register against the oldest expected issue.
  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".pc"},      ex_pc, e.pc);
      chk({tag, ".opcode"},  {27'd0, ex_opcode}, {27'd0, e.opc});
      chk({tag, ".funct3"},  {29'd0, ex_funct3}, {29'd0, e.f3});
      chk({tag, ".f7b5"},    {31'd0, ex_funct7b5}, {31'd0, e.f7});
      chk({tag, ".rd"},      {27'd0, ex_rd}, {27'd0, e.rd});
      chk({tag, ".imm"},     ex_imm, e.imm);
      chk({tag, ".illegal"}, {31'd0, ex_illegal}, {31'd0, e.ill});
      if (e.c1) chk({tag, ".rs1"}, ex_rs1_data, e.rs1d);
      if (e.c2) chk({tag, ".rs2"}, ex_rs2_data, e.rs2d);
    end
  endtask

  initial begin
    reset_n = 1'b0; de_valid = 1'b0; de_insn = 32'd0; de_pc = 32'd0;
    de_flush = 1'b0; flush_keep = 32'd0; wb_valid = 1'b0; wb_rd = 5'd0;
    wb_data = 32'd0; ex_stall = 1'b0;
    tick(); tick();
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_pc", ex_pc, RESET_PC);
    chk("rst.ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst.ex_imm", ex_imm, 32'd0);
    chk("rst.pend", dut.pend, 32'd0);
    reset_n = 1'b1;

    // addi x1,x0,5
    de_valid = 1'b1; de_insn = 32'h0050_0093; de_pc = 32'h100;
    #1 chk("addi.stall", {31'd0, de_stall}, 32'd0);
    push(32'h100, 5'b00100, 3'd0, 1'b0, 5'd1, 32'd0, 32'd0, 32'd5, 1'b0, 1'b1, 1'b0);
    tick();
    pop_check("addi_x1");
    chk("addi.pend", dut.pend, 32'h2);

    // add x2,x1,x1 back-to-back: RAW on x1
    de_insn = 32'h0010_8133; de_pc = 32'h104;
    #1 chk("raw.stall0", {31'd0, de_stall}, 32'd1);
    tick();
    chk("raw.bubble", {31'd0, ex_valid}, 32'd0);
    chk("raw.stall1", {31'd0, de_stall}, 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("raw.stall_wb", {31'd0, de_stall}, 32'd0);
    push(32'h104, 5'b01100, 3'd0, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    wb_valid = 1'b0; de_valid = 1'b0;
`else
    #1 chk("raw.stall_wb", {31'd0, de_stall}, 32'd1);
    tick();
    wb_valid = 1'b0;
    #1 chk("raw.stall_after", {31'd0, de_stall}, 32'd0);
    push(32'h104, 5'b01100, 3'd0, 1'b0, 5'd2, rf_val(5'd1), rf_val(5'd1), 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    de_valid = 1'b0;
`endif
    pop_check("add_x2");
    chk("add.pend", dut.pend, 32'h4);

    // execute backpressure with ex occupied, then beq x0,x0,-4
    ex_stall = 1'b1; de_valid = 1'b1; de_insn = 32'hFE00_0EE3; de_pc = 32'h108;
    #1 chk("exst.stall", {31'd0, de_stall}, 32'd1);
    tick();
    chk("exst.hold_valid", {31'd0, ex_valid}, 32'd1);
    chk("exst.hold_pc", ex_pc, 32'h104);
    chk("exst.hold_rd", {27'd0, ex_rd}, 32'd2);
    ex_stall = 1'b0;
    #1 chk("exst.release", {31'd0, de_stall}, 32'd0);
    push(32'h108, 5'b11000, 3'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
    tick();
    pop_check("beq");

    // illegal opcode 11111
    de_insn = 32'h0000_00FF; de_pc = 32'h10C;
    push(32'h10C, 5'b11111, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    pop_check("illegal");
    chk("illegal.pend", dut.pend, 32'h4);

    // lui x3,0x12345
    de_insn = 32'h1234_51B7; de_pc = 32'h110;
    push(32'h110, 5'b01101, 3'd5, 1'b0, 5'd3, 32'd0, 32'd0, 32'h1234_5000, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check("lui");
    chk("lui.pend", dut.pend, 32'hC);

    // jal x0,+8
    de_insn = 32'h0080_006F; de_pc = 32'h114;
    push(32'h114, 5'b11011, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check("jal_x0");
    chk("jal.pend", dut.pend, 32'hC);

    // addi x1,x0,7
    de_insn = 32'h0070_0093; de_pc = 32'h118;
    push(32'h118, 5'b00100, 3'd0, 1'b0, 5'd1, 32'd0, 32'd0, 32'd7, 1'b0, 1'b1, 1'b0);
    tick();
    pop_check("addi_x1b");
    chk("addi_x1b.pend", dut.pend, 32'hE);

    // addi x5,x0,1 while x2 retires
    de_insn = 32'h0010_0293; de_pc = 32'h11C; wb_valid = 1'b1; wb_rd = 5'd2;
    push(32'h11C, 5'b00100, 3'd0, 1'b0, 5'd5, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1, 1'b0);
    tick();
    wb_valid = 1'b0;
    pop_check("addi_x5");
    chk("addi_x5.pend", dut.pend, 32'h2A);

    // flush with x4 retiring in the same cycle; keep bit0 must be dropped
    de_insn = 32'h0010_8133; de_pc = 32'h120; de_flush = 1'b1; flush_keep = 32'h13;
    wb_valid = 1'b1; wb_rd = 5'd4;
    #1 chk("flush.stall", {31'd0, de_stall}, 32'd0);
    tick();
    de_flush = 1'b0; wb_valid = 1'b0; de_valid = 1'b0;
    chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.pend", dut.pend, 32'h2);

    // addi x0,x0,0 never marks a register pending
    de_valid = 1'b1; de_insn = 32'h0000_0013; de_pc = 32'h124;
    push(32'h124, 5'b00100, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    pop_check("nop");
    chk("nop.pend", dut.pend, 32'h2);

    // reset asserted mid-stall, between clock edges
    ex_stall = 1'b1; de_insn = 32'h0010_8133; de_pc = 32'h128;
    #1 chk("rst2.stall_before", {31'd0, de_stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst2.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst2.pend", dut.pend, 32'd0);
    chk("rst2.ex_pc", ex_pc, RESET_PC);
    chk("rst2.stall_after", {31'd0, de_stall}, 32'd0);
    de_valid = 1'b0; ex_stall = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
